// File: rtl/life_grid_pkg.sv
// Shared types and rule constants for the Life-like grid and its cells.
package life_grid_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fsm_e;

  // Bit k of a mask selects the outcome for k live neighbours.
  localparam logic [8:0] RULE_B3S23_BIRTH    = 9'b000001000;
  localparam logic [8:0] RULE_B3S23_SURVIVE  = 9'b000001100;
  localparam logic [8:0] RULE_B36S23_BIRTH   = 9'b001001000;
  localparam logic [8:0] RULE_B36S23_SURVIVE = 9'b000001100;
  localparam logic [8:0] RULE_B2S_BIRTH      = 9'b000000100;
  localparam logic [8:0] RULE_B2S_SURVIVE    = 9'b000000000;

  function automatic logic [3:0] popCount8(input logic [7:0] v);
    logic [3:0] sum;
    sum = '0;
    for (int k = 0; k < 8; k++) sum = sum + {3'b000, v[k]};
    return sum;
  endfunction

endpackage

// File: rtl/life_rule_cell.sv
// One automaton cell: counts its eight neighbours and applies the birth/survive masks.
module life_rule_cell
  import life_grid_pkg::*;
#(
  parameter logic [8:0] BIRTH   = RULE_B3S23_BIRTH,
  parameter logic [8:0] SURVIVE = RULE_B3S23_SURVIVE
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] nbr_i,
  input  logic       load_en_i,
  input  logic       load_data_i,
  input  logic       upd_en_i,
  output logic       state_o,
  output logic       next_o
);

  logic       state_q, state_d;
  logic [3:0] liveCount;
  logic       nextVal;

  always_comb begin
    liveCount = popCount8(nbr_i);
    nextVal   = state_q ? SURVIVE[liveCount] : BIRTH[liveCount];
    state_d   = state_q;
    if (load_en_i)     state_d = load_data_i;
    else if (upd_en_i) state_d = nextVal;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= 1'b0;
    else       state_q <= state_d;
  end

  assign state_o = state_q;
  assign next_o  = nextVal;

endmodule

// File: rtl/life_grid.sv
// Configurable Life-like grid: row-serial loading, step/free-run control,
// generation counter and stable/extinct detection with auto-halt.
module life_grid
  import life_grid_pkg::*;
#(
  parameter int         WIDTH   = 17,
  parameter int         HEIGHT  = 17,
  parameter bit         TORUS   = 1'b1,
  parameter logic [8:0] BIRTH   = RULE_B3S23_BIRTH,
  parameter logic [8:0] SURVIVE = RULE_B3S23_SURVIVE,
  parameter int         GEN_W   = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic [$clog2(HEIGHT)-1:0]   load_row,
  input  logic [WIDTH-1:0]            load_data,
  input  logic                        step_req,
  input  logic                        run,
  output logic [WIDTH*HEIGHT-1:0]     states,
  output logic [GEN_W-1:0]            gen_count,
  output logic                        gen_valid,
  output logic                        stable,
  output logic                        extinct,
  output logic                        halted
);

  localparam int N = WIDTH * HEIGHT;

  fsm_e             state_q, state_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             genValid_q, genValid_d;
  logic             stable_q, stable_d;
  logic             extinct_q, extinct_d;

  logic [N-1:0] cellState, cellNext, loadGrid;
  logic         loadFire, rowOk, doUpdate, nextStable, nextZero, stopRun;

  assign rowOk      = int'(load_row) < HEIGHT;
  assign loadFire   = load_valid && load_ready;
  assign nextStable = (cellNext == cellState);
  assign nextZero   = (cellNext == '0);
  assign stopRun    = nextStable || nextZero;

  // Load wins over step/run in IDLE; the first free-run update may already halt.
  always_comb begin
    state_d    = state_q;
    doUpdate   = 1'b0;
    load_ready = (state_q == IDLE);
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          state_d = IDLE;
        end else if (run) begin
          doUpdate = 1'b1;
          state_d  = stopRun ? HALT : RUN;
        end else if (step_req) begin
          doUpdate = 1'b1;
        end
      end
      RUN: begin
        if (!run) begin
          state_d = IDLE;
        end else begin
          doUpdate = 1'b1;
          if (stopRun) state_d = HALT;
        end
      end
      HALT: begin
        if (!run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    loadGrid = cellState;
    for (int r = 0; r < HEIGHT; r++) begin
      if (rowOk && int'(load_row) == r) loadGrid[r*WIDTH +: WIDTH] = load_data;
    end
  end

  always_comb begin
    gen_d      = gen_q;
    stable_d   = stable_q;
    extinct_d  = extinct_q;
    genValid_d = doUpdate;
    if (loadFire && rowOk) begin
      gen_d     = '0;
      stable_d  = 1'b0;
      extinct_d = (loadGrid == '0);
    end else if (doUpdate) begin
      gen_d     = (gen_q == {GEN_W{1'b1}}) ? gen_q : gen_q + 1'b1;
      stable_d  = nextStable;
      extinct_d = nextZero;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      gen_q      <= '0;
      genValid_q <= 1'b0;
      stable_q   <= 1'b0;
      extinct_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      gen_q      <= gen_d;
      genValid_q <= genValid_d;
      stable_q   <= stable_d;
      extinct_q  <= extinct_d;
    end
  end

  // Neighbour k (row-major over the 3x3 window, centre skipped) maps to nbr bit.
  for (genvar r = 0; r < HEIGHT; r++) begin : gRow
    for (genvar c = 0; c < WIDTH; c++) begin : gCol
      logic [7:0] nbr;
      for (genvar k = 0; k < 9; k++) begin : gNbr
        if (k != 4) begin : gReal
          localparam int RR = r + k / 3 - 1;
          localparam int CC = c + k % 3 - 1;
          localparam int NI = (k < 4) ? k : k - 1;
          if (TORUS) begin : gWrap
            assign nbr[NI] = cellState[((RR + HEIGHT) % HEIGHT) * WIDTH + (CC + WIDTH) % WIDTH];
          end else if (RR < 0 || RR >= HEIGHT || CC < 0 || CC >= WIDTH) begin : gEdge
            assign nbr[NI] = 1'b0;
          end else begin : gInner
            assign nbr[NI] = cellState[RR * WIDTH + CC];
          end
        end
      end

      life_rule_cell #(
        .BIRTH  (BIRTH),
        .SURVIVE(SURVIVE)
      ) uCell (
        .clock      (clock),
        .reset      (reset),
        .nbr_i      (nbr),
        .load_en_i  (loadFire && rowOk && int'(load_row) == r),
        .load_data_i(load_data[c]),
        .upd_en_i   (doUpdate),
        .state_o    (cellState[r*WIDTH + c]),
        .next_o     (cellNext[r*WIDTH + c])
      );
    end
  end

  assign states    = cellState;
  assign gen_count = gen_q;
  assign gen_valid = genValid_q;
  assign stable    = stable_q;
  assign extinct   = extinct_q;
  assign halted    = (state_q == HALT);

endmodule
